// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and debug
// halt/single-step, with saturating stall/flush event counters.
module pipe_hazard_ctrl (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemtoReg,
  input  logic        EX_RegWr,
  input  logic [4:0]  EX_Rt,
  input  logic        MEM_PCSrc,
  input  logic        Freeze,
  input  logic        StepReq,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        Pipe_EN,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic [1:0]  State,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic active;
  logic do_flush;
  logic do_stall;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_use = EX_MemtoReg & EX_RegWr & (EX_Rt != 5'd0) &
                    ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));

  // HALT only advances on a step cycle; StepReq is meaningless elsewhere.
  assign active   = (state_q != HALT) | StepReq;
  assign do_flush = active & MEM_PCSrc;
  // Back-to-back stalls are suppressed: the load has left EX after one bubble.
  assign do_stall = active & ~MEM_PCSrc & load_use & (state_q != STALL);

  always_comb begin
    PC_EN       = 1'b1;
    IFID_EN     = 1'b1;
    Pipe_EN     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    // During reset everything is enabled so pipeline registers see their own reset.
    if (Clrn) begin
      if (!active) begin
        PC_EN   = 1'b0;
        IFID_EN = 1'b0;
        Pipe_EN = 1'b0;
      end else if (do_flush) begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
      end else if (do_stall) begin
        PC_EN      = 1'b0;
        IFID_EN    = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = RUN;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Freeze)        state_d = HALT;
    else if (do_flush) state_d = FLUSH;
    else if (do_stall) state_d = STALL;
    if (do_flush) flush_cnt_d = sat_inc(flush_cnt_q);
    if (do_stall) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign State    = state_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-computed
// expectations, a monitor pops and compares them once per cycle.
module tb_pipe_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, EX_MemtoReg, EX_RegWr, MEM_PCSrc, Freeze, StepReq;
  logic        PC_EN, IFID_EN, Pipe_EN, IFID_Flush, IDEX_Flush, EXMEM_Flush;
  logic [1:0]  State;
  logic [15:0] StallCnt, FlushCnt;

  pipe_hazard_ctrl dut (
    .Clk(Clk), .Clrn(Clrn),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemtoReg(EX_MemtoReg), .EX_RegWr(EX_RegWr), .EX_Rt(EX_Rt),
    .MEM_PCSrc(MEM_PCSrc), .Freeze(Freeze), .StepReq(StepReq),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .Pipe_EN(Pipe_EN),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .State(State), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic [2:0]  en;
    logic [2:0]  fl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   vid     = 0;

  localparam logic [1:0] S_RUN = 2'd0, S_STL = 2'd1, S_FLS = 2'd2, S_HLT = 2'd3;

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec%0d: got %0h expected %0h", nm, id, act, req);
  endtask

  // en = {PC_EN, IFID_EN, Pipe_EN}; fl = {IFID_Flush, IDEX_Flush, EXMEM_Flush}
  task automatic vec(input logic clrn, input logic frz, input logic stp, input logic pcs,
                     input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic m2r, input logic rw, input logic [4:0] ert,
                     input logic [2:0] en, input logic [2:0] fl, input logic [1:0] st,
                     input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    @(negedge Clk);
    Clrn = clrn; Freeze = frz; StepReq = stp; MEM_PCSrc = pcs;
    ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses;
    EX_MemtoReg = m2r; EX_RegWr = rw; EX_Rt = ert;
    vid++;
    e.id = vid; e.en = en; e.fl = fl; e.st = st; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Shorthands: idle cycle and a load-use hit (lw $2 in EX, ID reads $2 as rs).
  task automatic idle(input logic frz, input logic stp, input logic [2:0] en,
                      input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    vec(1'b1, frz, stp, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, en, 3'b000, st, sc, fc);
  endtask

  task automatic lu(input logic [2:0] en, input logic [2:0] fl,
                    input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, en, fl, st, sc, fc);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("enables", e.id, {13'd0, PC_EN, IFID_EN, Pipe_EN}, {13'd0, e.en});
        chk("flushes", e.id, {13'd0, IFID_Flush, IDEX_Flush, EXMEM_Flush}, {13'd0, e.fl});
        chk("state",   e.id, {14'd0, State}, {14'd0, e.st});
        chk("stallcnt", e.id, StallCnt, e.sc);
        chk("flushcnt", e.id, FlushCnt, e.fc);
      end
    end
  end

  initial begin : stimulus
    int waited;
    Clrn = 1'b0; Freeze = 1'b0; StepReq = 1'b0; MEM_PCSrc = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
    EX_MemtoReg = 1'b0; EX_RegWr = 1'b0; EX_Rt = '0;
    @(posedge Clk);

    // reset state
    vec(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b111, 3'b000, S_RUN, 16'd0, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'd0, 16'd0);
    // load-use stall, held in STALL to show the one-cycle cap
    lu(3'b001, 3'b010, S_RUN, 16'd0, 16'd0);
    lu(3'b111, 3'b000, S_STL, 16'd1, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'd1, 16'd0);
    // $0 destination, and rt match with ID_UsesRt=0 / =1
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 3'b111, 3'b000, S_RUN, 16'd1, 16'd0);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 3'b111, 3'b000, S_RUN, 16'd1, 16'd0);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 3'b001, 3'b010, S_RUN, 16'd1, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_STL, 16'd2, 16'd0);
    // load without RegWr does not stall
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 3'b111, 3'b000, S_RUN, 16'd2, 16'd0);
    // taken branch together with a load-use hit: flush wins
    vec(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 3'b111, 3'b111, S_RUN, 16'd2, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_FLS, 16'd2, 16'd1);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'd2, 16'd1);
    // Freeze for 4 cycles, one step in cycle 3; branch+hazard in HALT ignored
    idle(1'b1, 1'b0, 3'b111, S_RUN, 16'd2, 16'd1);
    idle(1'b1, 1'b0, 3'b000, S_HLT, 16'd2, 16'd1);
    idle(1'b1, 1'b1, 3'b111, S_HLT, 16'd2, 16'd1);
    vec(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 3'b000, 3'b000, S_HLT, 16'd2, 16'd1);
    idle(1'b0, 1'b0, 3'b000, S_HLT, 16'd2, 16'd1);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'd2, 16'd1);
    // step cycle that takes a branch, then StepReq held for a second step
    idle(1'b1, 1'b0, 3'b111, S_RUN, 16'd2, 16'd1);
    vec(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b111, 3'b111, S_HLT, 16'd2, 16'd1);
    idle(1'b1, 1'b1, 3'b111, S_HLT, 16'd2, 16'd2);
    idle(1'b0, 1'b0, 3'b000, S_HLT, 16'd2, 16'd2);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'd2, 16'd2);
    // bring StallCnt to 5, enter HALT, then reset
    lu(3'b001, 3'b010, S_RUN, 16'd2, 16'd2);
    idle(1'b0, 1'b0, 3'b111, S_STL, 16'd3, 16'd2);
    lu(3'b001, 3'b010, S_RUN, 16'd3, 16'd2);
    idle(1'b0, 1'b0, 3'b111, S_STL, 16'd4, 16'd2);
    lu(3'b001, 3'b010, S_RUN, 16'd4, 16'd2);
    idle(1'b1, 1'b0, 3'b111, S_STL, 16'd5, 16'd2);
    idle(1'b1, 1'b0, 3'b000, S_HLT, 16'd5, 16'd2);
    vec(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 3'b111, 3'b000, S_HLT, 16'd5, 16'd2);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'd0, 16'd0);
    // saturation: preset StallCnt to FFFE, then three separated stalls
    @(posedge Clk);
    #1 force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    lu(3'b001, 3'b010, S_RUN, 16'hFFFE, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_STL, 16'hFFFF, 16'd0);
    lu(3'b001, 3'b010, S_RUN, 16'hFFFF, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_STL, 16'hFFFF, 16'd0);
    lu(3'b001, 3'b010, S_RUN, 16'hFFFF, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_STL, 16'hFFFF, 16'd0);
    idle(1'b0, 1'b0, 3'b111, S_RUN, 16'hFFFF, 16'd0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge Clk);
      #5;
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- Clk  in  1  sole clock, rising edge
- Clrn  in  1  synchronous active-low reset
- ID_Rs  in  5  rs field of instruction in ID
- ID_Rt  in  5  rt field of instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt (R-type, branch, store)
- EX_MemtoReg  in  1  instruction in EX is a load
- EX_RegWr  in  1  instruction in EX writes the register file
- EX_Rt  in  5  load destination register in EX
- MEM_PCSrc  in  1  branch/jump taken, resolved in MEM
- Freeze  in  1  debug halt request, level
- StepReq  in  1  debug single-step request, one-cycle pulse
- PC_EN  out  1  PC update enable
- IFID_EN  out  1  IF/ID register enable
- Pipe_EN  out  1  enable for ID/EX, EX/MEM, MEM/WR registers and register-file write
- IFID_Flush  out  1  load NOP into IF/ID
- IDEX_Flush  out  1  load bubble (all controls 0) into ID/EX
- EXMEM_Flush  out  1  load bubble into EX/MEM
- State  out  2  FSM state: RUN=0, STALL=1, FLUSH=2, HALT=3
- StallCnt  out  16  load-use stall cycle count
- FlushCnt  out  16  branch flush event count

Function
REQ-002 SHALL define load_use = EX_MemtoReg & EX_RegWr & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))).
REQ-003 SHALL compute all enable/flush outputs combinationally from current State and inputs (same-cycle effect); State and counters SHALL be registered.
REQ-004 SHALL define an active cycle as State in {RUN, STALL, FLUSH}, or State = HALT with StepReq = 1 (step cycle).
REQ-005 In an active cycle with MEM_PCSrc=1: PC_EN=1, IFID_EN=1, Pipe_EN=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1; load_use ignored (flush has priority).
REQ-006 In an active cycle with MEM_PCSrc=0, load_use=1, State != STALL: PC_EN=0, IFID_EN=0, Pipe_EN=1, IDEX_Flush=1, other flushes 0.
REQ-007 In State = STALL, load_use SHALL be ignored (stall capped at 1 consecutive cycle).
REQ-008 In any other active cycle: PC_EN=IFID_EN=Pipe_EN=1, all flushes 0.
REQ-009 In State = HALT with StepReq=0: PC_EN=IFID_EN=Pipe_EN=0, all flushes 0; MEM_PCSrc and load_use have no effect.
REQ-010 Next-state priority, evaluated at each rising edge with Clrn=1:
- Freeze=1 -> HALT (from any state; a step cycle returns to HALT).
- else flush applied this cycle -> FLUSH.
- else stall applied this cycle -> STALL.
- else -> RUN (includes HALT with Freeze=0, with or without StepReq).
REQ-011 FLUSH and STALL SHALL last exactly one cycle unless re-entered by REQ-010.
REQ-012 Freeze SHALL take effect the cycle after it is sampled high; the sampling cycle behaves per REQ-005..008.
REQ-013 StepReq SHALL be ignored outside HALT; a StepReq held high in HALT SHALL produce one step per cycle.
REQ-014 StallCnt SHALL increment by 1 per cycle with the REQ-006 stall applied; FlushCnt SHALL increment by 1 per cycle with REQ-005 applied; both SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-015 With Clrn=0 at a rising edge: State <= RUN, StallCnt <= 0, FlushCnt <= 0, overriding all other inputs, including mid-stall, mid-flush and in HALT.
REQ-016 While Clrn=0: PC_EN=IFID_EN=Pipe_EN=1 and all flush outputs 0, so pipeline registers observe their own reset.

Verification
REQ-017 SHALL cover these directed scenarios:
- lw $2 in EX (EX_MemtoReg=1, EX_RegWr=1, EX_Rt=2), ID_Rs=2 -> one cycle PC_EN=0, IFID_EN=0, IDEX_Flush=1; next cycle State=STALL, enables 1; StallCnt=1.
- EX_Rt=0 load, ID_Rs=0; also EX_Rt=3, ID_Rt=3, ID_UsesRt=0 -> no stall, State stays RUN.
- MEM_PCSrc=1 together with a load_use hit -> all three flushes 1, PC_EN=1; next State=FLUSH; FlushCnt=1, StallCnt unchanged.
- Freeze=1 for 4 cycles with StepReq pulsed once in cycle 3 -> enables 0 in HALT except exactly one step cycle with all enables 1; Freeze=0 -> RUN next cycle.
- Clrn=0 for 1 cycle while State=HALT and StallCnt=5 -> State=RUN, counters 0, enables 1.
- Force StallCnt to 16'hFFFE, apply 3 stalls separated by non-stall cycles -> StallCnt ends at 16'hFFFF.
